// File: rtl/rv4.sv
// rv4: 4-entry valid/ready elastic buffer with registered outputs.
// Storage is a small circular array; occupancy, pointers and all three
// handshake/data outputs are flops, so no output depends combinationally
// on datain_val, datain or dataout_rdy.
module rv4 #(
  parameter int unsigned wd = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          datain_val,
  input  logic [wd-1:0] datain,
  output logic          datain_rdy,
  output logic          dataout_val,
  output logic [wd-1:0] dataout,
  input  logic          dataout_rdy
);

  localparam int unsigned depth = 4;
  localparam int unsigned pw    = 2;
  localparam int unsigned cw    = 3;

  logic [wd-1:0] mem [depth];
  logic [pw-1:0] wr_ptr, wr_ptr_n;
  logic [pw-1:0] rd_ptr, rd_ptr_n;
  logic [cw-1:0] count, count_n;
  logic          rdy_n;
  logic          val_n;
  logic [wd-1:0] dout_n;
  logic          push_c;
  logic          pop_c;

  // Handshake qualification from registered ready/valid
  assign push_c = datain_val && datain_rdy;
  assign pop_c  = dataout_val && dataout_rdy;

  // Next pointers, occupancy and next registered outputs
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    count_n  = count;
    rdy_n    = 1'b1;
    val_n    = 1'b0;
    dout_n   = '0;

    if (push_c) wr_ptr_n = wr_ptr + pw'(1);
    if (pop_c)  rd_ptr_n = rd_ptr + pw'(1);

    case ({push_c, pop_c})
      2'b10:   count_n = count + cw'(1);
      2'b01:   count_n = count - cw'(1);
      default: count_n = count;
    endcase

    rdy_n = (count_n != cw'(depth));
    val_n = (count_n != cw'(0));

    // New head comes from the incoming word only when it lands in the head slot
    if (val_n) begin
      if (push_c && (wr_ptr == rd_ptr_n)) dout_n = datain;
      else                                dout_n = mem[rd_ptr_n];
    end
  end

  // Control state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      datain_rdy  <= 1'b1;
      dataout_val <= 1'b0;
      dataout     <= '0;
    end else begin
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      datain_rdy  <= rdy_n;
      dataout_val <= val_n;
      dataout     <= dout_n;
    end
  end

  // Storage array; not cleared on reset since dataout is masked while empty
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem[wr_ptr] <= datain;
  end

endmodule

// File: tb/tb_rv4.sv
// Self-checking bench for rv4 using a queue-based reference model.
module tb_rv4;

  localparam int unsigned WD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          datain_val;
  logic [WD-1:0] datain;
  logic          datain_rdy;
  logic          dataout_val;
  logic [WD-1:0] dataout;
  logic          dataout_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WD-1:0] q [$];
  logic          e_val;
  logic          e_rdy;
  logic [WD-1:0] e_dout;

  rv4 #(.wd(WD)) dut (
    .clk         (clk),
    .rst         (rst),
    .datain_val  (datain_val),
    .datain      (datain),
    .datain_rdy  (datain_rdy),
    .dataout_val (dataout_val),
    .dataout     (dataout),
    .dataout_rdy (dataout_rdy)
  );

  always #5 clk = ~clk;

  // Advance one edge, update the queue model, land 1 time unit after the edge
  task automatic step();
    logic p;
    logic o;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      p = datain_val && (q.size() < 4);
      o = dataout_rdy && (q.size() > 0);
      if (o) void'(q.pop_front());
      if (p) q.push_back(datain);
    end
    e_val  = (q.size() != 0);
    e_rdy  = (q.size() != 4);
    e_dout = e_val ? q[0] : '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; datain_val = 1'b1; datain = 4'd5; dataout_rdy = 1'b0;
    step();
    step();
    n_tests++;
    if ({dataout_val, datain_rdy, dataout} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got val=%b rdy=%b dout=%0d, want val=0 rdy=1 dout=0",
               dataout_val, datain_rdy, dataout);
    end
    rst = 1'b0; datain_val = 1'b0;
    step();
    n_tests++;
    if ({dataout_val, dataout} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_no_capture: got val=%b dout=%0d, want val=0 dout=0",
               dataout_val, dataout);
    end
  endtask

  task automatic test_streaming();
    datain_val = 1'b1; dataout_rdy = 1'b1; datain = 4'd0;
    for (int i = 0; i <= 8; i++) begin
      step();
      n_tests++;
      if ({dataout_val, datain_rdy, dataout} !== {1'b1, 1'b1, WD'(i)}) begin
        n_fail++;
        $display("FAIL stream_%0d: got val=%b rdy=%b dout=%0d, want val=1 rdy=1 dout=%0d",
                 i, dataout_val, datain_rdy, dataout, i);
      end
      #2 datain = WD'(i + 1);
    end
    datain_val = 1'b0;
    step();
    n_tests++;
    if ({dataout_val, dataout} !== {1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL stream_drain: got val=%b dout=%0d, want val=0 dout=0", dataout_val, dataout);
    end
  endtask

  task automatic test_fill_drain(input logic [WD-1:0] base);
    dataout_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      datain_val = 1'b1; datain = base + WD'(i);
      step();
      n_tests++;
      if ({dataout_val, datain_rdy, dataout} !== {1'b1, (i != 3), base}) begin
        n_fail++;
        $display("FAIL fill_%0d: got val=%b rdy=%b dout=%0d, want val=1 rdy=%b dout=%0d",
                 i, dataout_val, datain_rdy, dataout, (i != 3), base);
      end
    end
    datain = base + WD'(4);
    step();
    n_tests++;
    if ({datain_rdy, dataout, dut.count} !== {1'b0, base, 3'd4}) begin
      n_fail++;
      $display("FAIL fill_reject: got rdy=%b dout=%0d count=%0d, want rdy=0 dout=%0d count=4",
               datain_rdy, dataout, dut.count, base);
    end
    datain_val = 1'b0; dataout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({dataout_val, dataout} !== {1'b1, base + WD'(i)}) begin
        n_fail++;
        $display("FAIL drain_%0d: got val=%b dout=%0d, want val=1 dout=%0d",
                 i, dataout_val, dataout, base + WD'(i));
      end
      step();
    end
    n_tests++;
    if ({dataout_val, datain_rdy, dataout} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL drain_empty: got val=%b rdy=%b dout=%0d, want val=0 rdy=1 dout=0",
               dataout_val, datain_rdy, dataout);
    end
  endtask

  task automatic test_simultaneous();
    dataout_rdy = 1'b0; datain_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      datain = WD'(10 + i);
      step();
    end
    datain = 4'd13; dataout_rdy = 1'b1;
    step();
    n_tests++;
    if ({dut.count, dataout, datain_rdy} !== {3'd3, 4'd11, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_push_pop: got count=%0d dout=%0d rdy=%b, want count=3 dout=11 rdy=1",
               dut.count, dataout, datain_rdy);
    end
    dataout_rdy = 1'b0; datain = 4'd14;
    step();
    n_tests++;
    if ({datain_rdy, dataout} !== {1'b0, 4'd11}) begin
      n_fail++;
      $display("FAIL simul_full: got rdy=%b dout=%0d, want rdy=0 dout=11", datain_rdy, dataout);
    end
    datain_val = 1'b1; datain = 4'd15; dataout_rdy = 1'b1;
    step();
    n_tests++;
    if ({datain_rdy, dataout, dut.count} !== {1'b1, 4'd12, 3'd3}) begin
      n_fail++;
      $display("FAIL simul_rdy_return: got rdy=%b dout=%0d count=%0d, want rdy=1 dout=12 count=3",
               datain_rdy, dataout, dut.count);
    end
    datain_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({dataout_val, dataout} !== {e_val, e_dout}) begin
        n_fail++;
        $display("FAIL simul_order_%0d: got val=%b dout=%0d, want val=%b dout=%0d",
                 i, dataout_val, dataout, e_val, e_dout);
      end
    end
  endtask

  task automatic test_mid_reset();
    dataout_rdy = 1'b0; datain_val = 1'b1;
    datain = 4'd1; step();
    datain = 4'd2; step();
    rst = 1'b1; datain = 4'd3;
    step();
    rst = 1'b0; datain_val = 1'b0;
    n_tests++;
    if ({dataout_val, datain_rdy, dataout, dut.count} !== {1'b0, 1'b1, 4'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL midreset_empty: got val=%b rdy=%b dout=%0d count=%0d, want 0 1 0 0",
               dataout_val, datain_rdy, dataout, dut.count);
    end
    datain_val = 1'b1; datain = 4'd9;
    step();
    datain_val = 1'b0; dataout_rdy = 1'b1;
    n_tests++;
    if ({dataout_val, dataout} !== {1'b1, 4'd9}) begin
      n_fail++;
      $display("FAIL midreset_first: got val=%b dout=%0d, want val=1 dout=9", dataout_val, dataout);
    end
    step();
    n_tests++;
    if (dataout_val !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_drain: got val=%b, want val=0", dataout_val);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      datain_val  = ($urandom_range(0, 3) != 0);
      dataout_rdy = ($urandom_range(0, 2) != 0) ^ (i >= 200 && i < 260);
      datain      = WD'($urandom);
      step();
      n_tests++;
      if ({dataout_val, datain_rdy, dataout} !== {e_val, e_rdy, e_dout}) begin
        n_fail++;
        $display("FAIL random_%0d: got val=%b rdy=%b dout=%0d, want val=%b rdy=%b dout=%0d",
                 i, dataout_val, datain_rdy, dataout, e_val, e_rdy, e_dout);
      end
    end
    rst = 1'b0; datain_val = 1'b0;
  endtask

  initial begin
    rst = 1'b0; datain_val = 1'b0; datain = '0; dataout_rdy = 1'b0;
    test_reset();
    test_streaming();
    test_fill_drain(4'd4);
    test_fill_drain(4'd4);
    test_fill_drain(4'd9);
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv4.md
# rv4

rv4 is a 4-entry valid/ready elastic buffer for a `wd`-bit data stream. It sits between an upstream producer and a downstream consumer. It decouples their handshakes and sustains one transfer per clock when the consumer is ready. Data leaves in strict FIFO order, with no loss and no duplication.

## Interface
- `wd`, default 4: data width in bits (minimum 1).
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, synchronous and active-high; sampled on the rising edge of `clk`.
- `datain_val`  input  1  upstream asserts when `datain` holds a valid word.
- `datain`  input  wd  upstream data word.
- `datain_rdy`  output  1  buffer can accept a word this cycle.
- `dataout_val`  output  1  `dataout` holds a valid word.
- `dataout`  output  wd  head-of-buffer data word.
- `dataout_rdy`  input  1  downstream can accept a word this cycle.

## Operation
- Storage: 4 registers of `wd` bits, a 2-bit write pointer, a 2-bit read pointer and a 3-bit occupancy count (0..4).
- Push: occurs when `datain_val && datain_rdy` is true at a rising edge.
  - Writes `datain` to the entry at the write pointer.
  - Write pointer increments modulo 4.
- Pop: occurs when `dataout_val && dataout_rdy` is true at a rising edge.
  - Read pointer increments modulo 4.
- Count update per edge:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged.
  - Neither: unchanged.
- `datain_rdy = (count != 4)`. It is a function of registered state only, with no combinational path from `dataout_rdy`.
- `dataout_val = (count != 0)`.
- `dataout`:
  - Equals the entry at the read pointer when `dataout_val` is 1.
  - Forced to 0 when `dataout_val` is 0.
- Full (count = 4): `datain_rdy` = 0. A pop that edge leaves count 3, so `datain_rdy` returns to 1 on the next cycle. There is no same-cycle push while full.
- Empty (count = 0): no pop is possible. A push that edge makes count 1 with `dataout_val` = 1. There is no combinational bypass from `datain` to `dataout`.
- Pointer wrap-around from 3 to 0 is transparent; ordering is preserved across the wrap.
- Inputs are sampled only at the rising edge. `datain` and `datain_val` may change at any time between edges.
- `datain` is ignored when `datain_val` = 0 or `datain_rdy` = 0.
- Stall hold: while `dataout_val` = 1 and `dataout_rdy` = 0, `dataout` and `dataout_val` stay constant.
- Storage contents are not cleared on reset, since `dataout` is masked to 0 while empty.

## Timing
- Reset: on a rising edge with `rst` = 1:
  - count, write pointer and read pointer go to 0.
  - Outputs: `dataout_val` = 0, `dataout` = 0, `datain_rdy` = 1.
- Reset priority:
  - Reset takes priority over a simultaneous push or pop.
  - Reset mid-operation discards all buffered words.
  - The first edge after `rst` falls may accept a push.
- Latency: a word pushed at edge N appears on `dataout` after edge N when the buffer was empty. Otherwise it appears after all older words have been popped.
- Throughput: with `datain_val` = 1 and `dataout_rdy` = 1 continuously, one word passes per cycle. Occupancy stays at 1, with dataout lagging datain by one cycle.
- All outputs are derived from registers; none depends combinationally on `datain_val`, `datain` or `dataout_rdy`.

## Test plan
- Reset: assert `rst` for 2 edges with `datain_val` = 1.
  - Required: `dataout_val` = 0, `dataout` = 0 and `datain_rdy` = 1 after reset.
  - Required: no word is captured during reset.
- Streaming: after reset, hold `datain_val` = 1 and `dataout_rdy` = 1, and change `datain` mid-cycle through 0,1,…,8.
  - Required: `dataout` shows each word sampled at the prior edge, in order.
  - Required: `dataout_val` stays 1 and `datain_rdy` stays 1.
- Fill: with `dataout_rdy` = 0, push 4,5,6,7.
  - Required: `datain_rdy` = 0 after the 4th push.
  - Required: a 5th offered word (8) is not accepted.
  - Required: `dataout` holds 4 throughout.
- Drain and wrap: from full, set `dataout_rdy` = 1 and `datain_val` = 0.
  - Required: `dataout` = 4,5,6,7 on consecutive cycles, then `dataout_val` = 0 and `dataout` = 0.
  - Repeat the fill to confirm order across the pointer wrap.
- Simultaneous push/pop at count 3: push A and pop on the same edge.
  - Required: count stays 3 and order is preserved.
  - Required: at count 4, a pop re-enables `datain_rdy` one cycle later.
- Mid-operation reset: with count 2, assert `rst` for 1 edge.
  - Required: the buffer is empty.
  - Required: the next pushed word 9 is the first word output.
